// File: rtl/vga_scene_pipeline.sv
// VGA scene renderer: pixel/line counters, tile addressing, Mario overlay,
// and a two-stage registered colour/sync pipeline.
module vga_scene_pipeline #(
    parameter int BDR           = 0,
    parameter int SKY           = 1,
    parameter int BLK           = 2,
    parameter int GND           = 3,
    parameter int MARIO_WIDTH   = 42,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int BLOCK_WIDTH   = 40,
    parameter int H_FP          = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BP          = 48,
    parameter int V_FP          = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BP          = 33
) (
    input  logic               vga_clock,
    input  logic               reset,
    input  logic signed [31:0] mario_x,
    input  logic signed [31:0] mario_y,
    output logic        [3:0]  tile_row,
    output logic        [4:0]  tile_col,
    input  logic        [1:0]  tile_type,
    output logic               hsync,
    output logic               vsync,
    output logic        [3:0]  vga_red,
    output logic        [3:0]  vga_green,
    output logic        [3:0]  vga_blue,
    output logic               frame_tick
);

    localparam logic [11:0] H_LAST = 12'(SCREEN_WIDTH + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] V_LAST = 12'(SCREEN_HEIGHT + V_FP + V_SYNC + V_BP - 1);
    localparam logic [11:0] H_VIS  = 12'(SCREEN_WIDTH);
    localparam logic [11:0] V_VIS  = 12'(SCREEN_HEIGHT);
    localparam logic [11:0] HS_BEG = 12'(SCREEN_WIDTH + H_FP);
    localparam logic [11:0] HS_END = 12'(SCREEN_WIDTH + H_FP + H_SYNC - 1);
    localparam logic [11:0] VS_BEG = 12'(SCREEN_HEIGHT + V_FP);
    localparam logic [11:0] VS_END = 12'(SCREEN_HEIGHT + V_FP + V_SYNC - 1);
    localparam logic [5:0]  SUB_LAST = 6'(BLOCK_WIDTH - 1);
    localparam logic signed [31:0] MW = 32'(MARIO_WIDTH);

    logic        run;
    logic [11:0] h_count, v_count, h_nxt, v_nxt;
    logic [5:0]  sub_h, sub_v, sub_h_nxt, sub_v_nxt;
    logic [4:0]  col_nxt;
    logic [3:0]  row_nxt;
    logic        line_end;
    logic signed [31:0] mx, my, hs, vs;
    logic        in_mario;
    logic        s1_blank, s1_mario, s1_hs, s1_vs;
    logic [11:0] rgb_nxt;

    // run holds the counters at 0 for the first edge after reset release
    assign line_end = run && (h_count == H_LAST);

    always_comb begin
        h_nxt     = h_count;
        v_nxt     = v_count;
        sub_h_nxt = sub_h;
        sub_v_nxt = sub_v;
        col_nxt   = tile_col;
        row_nxt   = tile_row;
        if (line_end) begin
            h_nxt = '0;
            v_nxt = (v_count == V_LAST) ? '0 : v_count + 12'd1;
        end else if (run) begin
            h_nxt = h_count + 12'd1;
        end
        if (h_nxt == '0) begin
            sub_h_nxt = '0;
            col_nxt   = '0;
        end else if (h_nxt < H_VIS) begin
            if (sub_h == SUB_LAST) begin
                sub_h_nxt = '0;
                col_nxt   = tile_col + 5'd1;
            end else begin
                sub_h_nxt = sub_h + 6'd1;
            end
        end
        if (v_nxt == '0) begin
            sub_v_nxt = '0;
            row_nxt   = '0;
        end else if (line_end && v_nxt < V_VIS) begin
            if (sub_v == SUB_LAST) begin
                sub_v_nxt = '0;
                row_nxt   = tile_row + 4'd1;
            end else begin
                sub_v_nxt = sub_v + 6'd1;
            end
        end
    end

    assign hs = $signed({20'd0, h_count});
    assign vs = $signed({20'd0, v_count});
    assign in_mario = (hs >= mx) && (hs < mx + MW) &&
                      (vs >= my) && (vs < my + MW);

    always_comb begin
        rgb_nxt = 12'h000;
        priority case (1'b1)
            s1_blank:                  rgb_nxt = 12'h000;
            s1_mario:                  rgb_nxt = 12'hF00;
            tile_type == 2'(SKY):      rgb_nxt = 12'h68F;
            tile_type == 2'(BLK):      rgb_nxt = 12'hA50;
            tile_type == 2'(GND):      rgb_nxt = 12'h530;
            default:                   rgb_nxt = 12'h000;
        endcase
    end

    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            run        <= 1'b0;
            h_count    <= '0;
            v_count    <= '0;
            sub_h      <= '0;
            sub_v      <= '0;
            tile_col   <= '0;
            tile_row   <= '0;
            mx         <= '0;
            my         <= '0;
            s1_blank   <= 1'b0;
            s1_mario   <= 1'b0;
            s1_hs      <= 1'b0;
            s1_vs      <= 1'b0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            vga_red    <= '0;
            vga_green  <= '0;
            vga_blue   <= '0;
            frame_tick <= 1'b0;
        end else begin
            run        <= 1'b1;
            h_count    <= h_nxt;
            v_count    <= v_nxt;
            sub_h      <= sub_h_nxt;
            sub_v      <= sub_v_nxt;
            tile_col   <= col_nxt;
            tile_row   <= row_nxt;
            if (h_count == '0 && v_count == VS_BEG) begin
                mx <= mario_x;
                my <= mario_y;
            end
            s1_blank   <= (h_count >= H_VIS) || (v_count >= V_VIS);
            s1_mario   <= in_mario;
            s1_hs      <= (h_count >= HS_BEG) && (h_count <= HS_END);
            s1_vs      <= (v_count >= VS_BEG) && (v_count <= VS_END);
            hsync      <= ~s1_hs;
            vsync      <= ~s1_vs;
            {vga_red, vga_green, vga_blue} <= rgb_nxt;
            frame_tick <= (h_nxt == '0) && (v_nxt == V_VIS);
        end
    end

endmodule

// File: tb/tb_vga_scene_pipeline.sv
// Directed bench for vga_scene_pipeline on a reduced raster
// (120x120 visible, 136x126 total) so several frames fit in a short run.
module tb_vga_scene_pipeline;

    localparam int SW = 120, SH = 120;
    localparam int HFP = 4, HSY = 8, HBP = 4;
    localparam int VFP = 2, VSY = 2, VBP = 2;
    localparam int HT = SW + HFP + HSY + HBP;
    localparam int VT = SH + VFP + VSY + VBP;
    localparam int FR = HT * VT;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [31:0] mario_x = 32'sd60;
    logic signed [31:0] mario_y = 32'sd50;
    logic        [3:0]  tile_row;
    logic        [4:0]  tile_col;
    logic        [1:0]  tile_type = 2'd1;
    logic               hsync, vsync, frame_tick;
    logic        [3:0]  vga_red, vga_green, vga_blue;
    int                 mode = 0;
    int                 cyc;
    int                 nchk = 0;
    int                 nerr = 0;

    vga_scene_pipeline #(
        .SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH),
        .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
    ) dut (
        .vga_clock(clk), .reset(rst),
        .mario_x(mario_x), .mario_y(mario_y),
        .tile_row(tile_row), .tile_col(tile_col), .tile_type(tile_type),
        .hsync(hsync), .vsync(vsync),
        .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // cycle 0 is the first rising edge after reset release
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= -1;
        else     cyc <= cyc + 1;
    end

    // Tile memory model: one-cycle read latency
    always @(posedge clk) begin
        if (mode == 0) tile_type <= 2'd1;
        else           tile_type <= (tile_row == 4'd1) ? 2'd3 : 2'd2;
    end

    function automatic int pix(int f, int h, int v);
        return f * FR + v * HT + h + 2;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_to(int t);
        int guard;
        guard = 0;
        if (cyc > t) begin
            nerr++;
            $display("FAIL wait_to: cycle %0d already past %0d", cyc, t);
        end
        while (cyc < t && guard < 200000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != t) begin
            nerr++;
            $display("FAIL wait_to: at cycle %0d expected %0d", cyc, t);
        end
    endtask

    function automatic logic [31:0] rgb();
        return {20'd0, vga_red, vga_green, vga_blue};
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rgb", rgb(), 32'h000);
        chk("rst_hsync", {31'd0, hsync}, 32'd1);
        chk("rst_vsync", {31'd0, vsync}, 32'd1);
        chk("rst_tick", {31'd0, frame_tick}, 32'd0);
        chk("rst_tile", {23'd0, tile_row, tile_col}, 32'd0);
        rst = 1'b0;

        // frame 0: latched position is the reset value (0,0)
        wait_to(0);  chk("col_c0", {27'd0, tile_col}, 32'd0);
        wait_to(2);  chk("f0_px00", rgb(), 32'hF00);
        wait_to(45); chk("col_h45", {27'd0, tile_col}, 32'd1);
        wait_to(125); chk("hs_125", {31'd0, hsync}, 32'd1);
        wait_to(126); chk("hs_126", {31'd0, hsync}, 32'd0);
        wait_to(130);
        chk("col_held", {27'd0, tile_col}, 32'd2);
        chk("blank_130", rgb(), 32'h000);
        wait_to(133); chk("hs_133", {31'd0, hsync}, 32'd0);
        wait_to(134); chk("hs_134", {31'd0, hsync}, 32'd1);
        wait_to(HT); chk("col_wrap", {27'd0, tile_col}, 32'd0);
        wait_to(45 * HT + 5); chk("row_v45", {28'd0, tile_row}, 32'd1);
        wait_to(pix(0, 50, 50)); chk("f0_sky", rgb(), 32'h68F);
        wait_to(SH * HT - 1); chk("tick_pre", {31'd0, frame_tick}, 32'd0);
        wait_to(SH * HT);     chk("tick_on", {31'd0, frame_tick}, 32'd1);
        wait_to(SH * HT + 1); chk("tick_post", {31'd0, frame_tick}, 32'd0);
        wait_to(122 * HT + 1); chk("vs_pre", {31'd0, vsync}, 32'd1);
        wait_to(122 * HT + 2); chk("vs_on", {31'd0, vsync}, 32'd0);
        wait_to(124 * HT + 1); chk("vs_end", {31'd0, vsync}, 32'd0);
        wait_to(124 * HT + 2); chk("vs_off", {31'd0, vsync}, 32'd1);

        // frame 1: Mario at (60,50)
        wait_to(pix(1, 59, 50));  chk("f1_59_50", rgb(), 32'h68F);
        wait_to(pix(1, 60, 50));  chk("f1_60_50", rgb(), 32'hF00);
        wait_to(pix(1, 102, 50)); chk("f1_102_50", rgb(), 32'h68F);
        wait_to(FR + 70 * HT);
        mario_y = 32'sd90;
        wait_to(pix(1, 60, 80));  chk("f1_hold_y", rgb(), 32'hF00);
        wait_to(pix(1, 101, 91)); chk("f1_101_91", rgb(), 32'hF00);
        wait_to(FR + SH * HT);    chk("tick_f1", {31'd0, frame_tick}, 32'd1);
        wait_to(2 * FR - 10);
        mode = 1;

        // frame 2: Mario at (60,90), ground on tile row 1
        wait_to(pix(2, 110, 79)); chk("f2_gnd", rgb(), 32'h530);
        wait_to(pix(2, 60, 80));  chk("f2_60_80", rgb(), 32'hA50);
        wait_to(pix(2, 110, 80)); chk("f2_blk", rgb(), 32'hA50);
        wait_to(pix(2, 60, 100)); chk("f2_new_y", rgb(), 32'hF00);
        wait_to(2 * FR + 121 * HT);
        mode = 0;
        mario_x = -32'sd20;
        mario_y = 32'sd0;

        // frame 3: Mario clipped at the left edge
        wait_to(pix(3, 0, 0));    chk("f3_0_0", rgb(), 32'hF00);
        wait_to(pix(3, 22, 0));   chk("f3_22_0", rgb(), 32'h68F);
        wait_to(pix(3, 130, 0));  chk("f3_blank0", rgb(), 32'h000);
        wait_to(pix(3, 125, 10)); chk("f3_blank10", rgb(), 32'h000);
        wait_to(pix(3, 21, 41));  chk("f3_21_41", rgb(), 32'hF00);
        wait_to(pix(3, 22, 41));  chk("f3_22_41", rgb(), 32'h68F);
        wait_to(pix(3, 6, 45));   chk("pre_rst", rgb(), 32'h68F);

        rst = 1'b1;
        #1;
        chk("mid_rst_rgb", rgb(), 32'h000);
        chk("mid_rst_hs", {31'd0, hsync}, 32'd1);
        chk("mid_rst_vs", {31'd0, vsync}, 32'd1);
        chk("mid_rst_row", {28'd0, tile_row}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_to(0); chk("re_col", {27'd0, tile_col}, 32'd0);
        wait_to(2); chk("re_px00", rgb(), 32'hF00);
        wait_to(126); chk("re_hs", {31'd0, hsync}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
